// File: rtl/lms_sync_fifo_if.sv
// rtl/lms_sync_fifo_if.sv - handshake, status and monitor bundle for lms_sync_fifo
interface lms_sync_fifo_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 10
);
    // write side
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   full;
    logic                   almost_full;
    // read side
    logic                   rd_en;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_valid;
    logic                   empty;
    logic                   almost_empty;
    // control, thresholds and monitors
    logic                   flush;
    logic                   err_clr;
    logic [DEPTH_WIDTH:0]   af_thresh;
    logic [DEPTH_WIDTH:0]   ae_thresh;
    logic [DEPTH_WIDTH:0]   water_level;
    logic [DEPTH_WIDTH:0]   peak_level;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output wr_en, wr_data, rd_en, flush, err_clr, af_thresh, ae_thresh,
        input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
               water_level, peak_level, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, flush, err_clr, af_thresh, ae_thresh,
        output full, almost_full, rd_data, rd_valid, empty, almost_empty,
               water_level, peak_level, overflow, underflow
    );
endinterface

// File: rtl/lms_sync_fifo.sv
// rtl/lms_sync_fifo.sv - single-clock FIFO with standard/FWFT read, thresholds, flush and error/peak monitors
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of lms_sync_fifo_if (write/read handshakes, flush,
//                thresholds, occupancy, peak and sticky error flags)
module lms_sync_fifo #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 10,
    parameter int FWFT        = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    lms_sync_fifo_if.slave  bus
);
    localparam int D = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] LEVEL_FULL = (DEPTH_WIDTH+1)'(D);

    logic [DATA_WIDTH-1:0]  mem_q [D];
    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_WIDTH:0]   level_q, level_d;
    logic [DEPTH_WIDTH:0]   peak_q, peak_d;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    // standard mode: one-cycle read strobe; FWFT mode: output register holds the head word
    logic                   rd_valid_q, rd_valid_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;

    logic                   full, empty, push, pop, mem_we;
    logic [DEPTH_WIDTH:0]   mem_cnt;

    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);
    // flush takes priority over both requests and never counts as an error
    assign push  = bus.wr_en && !full  && !bus.flush;
    assign pop   = bus.rd_en && !empty && !bus.flush;
    // in FWFT mode the level includes the output register, so the array holds one fewer
    assign mem_cnt = level_q - (DEPTH_WIDTH+1)'((FWFT != 0) && rd_valid_q);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        mem_we     = push;

        if (FWFT == 0) begin
            rd_valid_d = pop;
            if (pop) begin
                rd_data_d = mem_q[rd_ptr_q];
                rd_ptr_d  = rd_ptr_q + DEPTH_WIDTH'(1);
            end
        end else if (pop || !rd_valid_q) begin
            // refill the output register: array head first, else bypass the incoming write
            if (mem_cnt != '0) begin
                rd_data_d  = mem_q[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + DEPTH_WIDTH'(1);
                rd_valid_d = 1'b1;
            end else if (push) begin
                rd_data_d  = bus.wr_data;
                rd_valid_d = 1'b1;
                mem_we     = 1'b0;
            end else begin
                rd_valid_d = 1'b0;
            end
        end

        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(1);
        end

        level_d = level_q + (DEPTH_WIDTH+1)'(push) - (DEPTH_WIDTH+1)'(pop);

        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            rd_valid_d = 1'b0;
        end

        // a new error or level in the err_clr cycle wins over the clear
        overflow_d  = (bus.wr_en && full  && !bus.flush) || (overflow_q  && !bus.err_clr);
        underflow_d = (bus.rd_en && empty && !bus.flush) || (underflow_q && !bus.err_clr);
        peak_d      = (bus.err_clr || (level_q > peak_q)) ? level_q : peak_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            peak_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            peak_q      <= peak_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // storage is not reset: contents are meaningless once pointers are cleared
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level_q >= bus.af_thresh);
    assign bus.almost_empty = (level_q <= bus.ae_thresh);
    assign bus.water_level  = level_q;
    assign bus.peak_level   = peak_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = (FWFT != 0) ? !empty : rd_valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_lms_sync_fifo.sv
// tb/tb_lms_sync_fifo.sv - scoreboard bench running standard and FWFT instances in lockstep
module tb_lms_sync_fifo;
    logic clk;
    logic rst_n;

    lms_sync_fifo_if #(.DATA_WIDTH(16), .DEPTH_WIDTH(4)) sif ();
    lms_sync_fifo_if #(.DATA_WIDTH(16), .DEPTH_WIDTH(4)) fif ();

    lms_sync_fifo #(.DATA_WIDTH(16), .DEPTH_WIDTH(4), .FWFT(0)) u_std (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    lms_sync_fifo #(.DATA_WIDTH(16), .DEPTH_WIDTH(4), .FWFT(1)) u_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fif)
    );

    assign fif.wr_en     = sif.wr_en;
    assign fif.wr_data   = sif.wr_data;
    assign fif.rd_en     = sif.rd_en;
    assign fif.flush     = sif.flush;
    assign fif.err_clr   = sif.err_clr;
    assign fif.af_thresh = sif.af_thresh;
    assign fif.ae_thresh = sif.ae_thresh;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: queue of words held, sticky flags, peak, pending standard strobe
    logic [15:0] mq[$];
    logic [15:0] std_exp[$];
    logic [15:0] fwft_exp[$];
    bit          m_ovf, m_unf, m_std_valid;
    int          m_peak;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic check_outputs();
        int lvl;
        int af;
        int ae;
        lvl = mq.size();
        af  = int'(sif.af_thresh);
        ae  = int'(sif.ae_thresh);
        chk("std_level",      32'(sif.water_level),  32'(lvl));
        chk("std_full",       32'(sif.full),         32'(lvl == 16));
        chk("std_empty",      32'(sif.empty),        32'(lvl == 0));
        chk("std_afull",      32'(sif.almost_full),  32'(lvl >= af));
        chk("std_aempty",     32'(sif.almost_empty), 32'(lvl <= ae));
        chk("std_overflow",   32'(sif.overflow),     32'(m_ovf));
        chk("std_underflow",  32'(sif.underflow),    32'(m_unf));
        chk("std_peak",       32'(sif.peak_level),   32'(m_peak));
        chk("std_rd_valid",   32'(sif.rd_valid),     32'(m_std_valid));
        chk("fwft_level",     32'(fif.water_level),  32'(lvl));
        chk("fwft_full",      32'(fif.full),         32'(lvl == 16));
        chk("fwft_empty",     32'(fif.empty),        32'(lvl == 0));
        chk("fwft_afull",     32'(fif.almost_full),  32'(lvl >= af));
        chk("fwft_aempty",    32'(fif.almost_empty), 32'(lvl <= ae));
        chk("fwft_overflow",  32'(fif.overflow),     32'(m_ovf));
        chk("fwft_underflow", 32'(fif.underflow),    32'(m_unf));
        chk("fwft_peak",      32'(fif.peak_level),   32'(m_peak));
        chk("fwft_rd_valid",  32'(fif.rd_valid),     32'(lvl > 0));
        if (lvl > 0) chk("fwft_head", 32'(fif.rd_data), 32'(mq[0]));
    endtask

    task automatic check_reset_values();
        logic af_zero;
        af_zero = (sif.af_thresh == '0);
        chk("rst_std_empty",   32'(sif.empty),        32'd1);
        chk("rst_std_full",    32'(sif.full),         32'd0);
        chk("rst_std_valid",   32'(sif.rd_valid),     32'd0);
        chk("rst_std_data",    32'(sif.rd_data),      32'd0);
        chk("rst_std_level",   32'(sif.water_level),  32'd0);
        chk("rst_std_peak",    32'(sif.peak_level),   32'd0);
        chk("rst_std_ovf",     32'(sif.overflow),     32'd0);
        chk("rst_std_unf",     32'(sif.underflow),    32'd0);
        chk("rst_std_aempty",  32'(sif.almost_empty), 32'd1);
        chk("rst_std_afull",   32'(sif.almost_full),  32'(af_zero));
        chk("rst_fwft_empty",  32'(fif.empty),        32'd1);
        chk("rst_fwft_valid",  32'(fif.rd_valid),     32'd0);
        chk("rst_fwft_data",   32'(fif.rd_data),      32'd0);
        chk("rst_fwft_level",  32'(fif.water_level),  32'd0);
        chk("rst_fwft_peak",   32'(fif.peak_level),   32'd0);
        chk("rst_fwft_ovf",    32'(fif.overflow),     32'd0);
        chk("rst_fwft_unf",    32'(fif.underflow),    32'd0);
    endtask

    task automatic model_clear();
        mq.delete();
        std_exp.delete();
        fwft_exp.delete();
        m_ovf = 0;
        m_unf = 0;
        m_std_valid = 0;
        m_peak = 0;
    endtask

    // One cycle: check the state left by the previous edge, then present new
    // inputs and advance the model to what the next edge must produce.
    task automatic step(input bit wr, input logic [15:0] wd, input bit rd, input bit fl, input bit ec);
        int lvl;
        int base;
        logic [15:0] h;
        @(posedge clk);
        #1;
        check_outputs();
        sif.wr_en   = wr;
        sif.wr_data = wd;
        sif.rd_en   = rd;
        sif.flush   = fl;
        sif.err_clr = ec;
        lvl   = mq.size();
        base  = ec ? 0 : m_peak;
        m_peak = (lvl > base) ? lvl : base;
        m_ovf = (wr && lvl == 16 && !fl) || (m_ovf && !ec);
        m_unf = (rd && lvl == 0 && !fl) || (m_unf && !ec);
        m_std_valid = 0;
        if (fl) begin
            mq.delete();
        end else begin
            if (rd && lvl > 0) begin
                h = mq.pop_front();
                std_exp.push_back(h);
                fwft_exp.push_back(h);
                m_std_valid = 1;
            end
            if (wr && lvl < 16) mq.push_back(wd);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0, 0);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_clear();
        sif.wr_en   = 0;
        sif.rd_en   = 0;
        sif.flush   = 0;
        sif.err_clr = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // data monitors: standard pulses and FWFT acknowledged heads
    always @(negedge clk) begin
        if (rst_n && sif.rd_valid) begin
            if (std_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL std_data: unexpected rd_valid with data %0h at %0t", sif.rd_data, $time);
            end else begin
                chk("std_data", 32'(sif.rd_data), 32'(std_exp.pop_front()));
            end
        end
        if (rst_n && fif.rd_valid && fif.rd_en && !fif.flush) begin
            if (fwft_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL fwft_data: unexpected pop of %0h at %0t", fif.rd_data, $time);
            end else begin
                chk("fwft_data", 32'(fif.rd_data), 32'(fwft_exp.pop_front()));
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        sif.wr_en     = 0;
        sif.wr_data   = '0;
        sif.rd_en     = 0;
        sif.flush     = 0;
        sif.err_clr   = 0;
        sif.af_thresh = 5'd12;
        sif.ae_thresh = 5'd3;
        model_clear();
        #2;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // fill 1..16 then drain in order, thresholds 12/3
        for (int i = 1; i <= 16; i++) step(1, 16'(i), 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 16'h0, 1, 0, 0);
        idle(2);

        // overflow with 0xBEEF, underflow on empty, then err_clr
        for (int i = 1; i <= 16; i++) step(1, 16'(16'h100 + i), 0, 0, 0);
        step(1, 16'hBEEF, 0, 0, 0);
        step(1, 16'hBEEF, 1, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 16'h0, 1, 0, 0);
        step(0, 16'h0, 1, 0, 0);
        step(1, 16'h5555, 1, 0, 0);
        step(0, 16'h0, 1, 0, 0);
        idle(1);
        step(0, 16'h0, 0, 0, 1);
        idle(2);

        // single word into empty FIFO then pop
        step(1, 16'h1234, 0, 0, 0);
        step(0, 16'h0, 1, 0, 0);
        idle(2);

        // sustained read+write at level 8 across pointer wrap
        for (int i = 0; i < 8; i++) step(1, 16'($urandom), 0, 0, 0);
        for (int i = 0; i < 64; i++) step(1, 16'($urandom), 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 16'h0, 1, 0, 0);
        idle(1);

        // almost_full constantly high with af_thresh=0
        sif.af_thresh = 5'd0;
        idle(2);
        step(1, 16'hA5A5, 0, 0, 0);
        step(0, 16'h0, 1, 0, 0);
        idle(1);
        sif.af_thresh = 5'd12;

        // flush at level 10 with a concurrent write; peak stays 10
        step(0, 16'h0, 0, 0, 1);
        idle(1);
        for (int i = 0; i < 10; i++) step(1, 16'(16'h200 + i), 0, 0, 0);
        step(1, 16'hDEAD, 0, 1, 0);
        idle(2);
        step(1, 16'h0777, 0, 0, 0);
        step(0, 16'h0, 1, 0, 0);
        idle(1);

        // randomized traffic with occasional flush, err_clr and threshold changes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                sif.af_thresh = 5'($urandom_range(0, 16));
                sif.ae_thresh = 5'($urandom_range(0, 16));
            end
            step(($urandom_range(0, 9) < 6), 16'($urandom), ($urandom_range(0, 9) < 5),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0));
        end

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 6; i++) step(1, 16'($urandom), (i > 2), 0, 0);
        reset_mid();
        for (int i = 0; i < 4; i++) step(1, 16'(16'h300 + i), 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 0, 0);
        idle(3);

        chk("std_queue_drained",  32'(std_exp.size()),  32'd0);
        chk("fwft_queue_drained", 32'(fwft_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
